// File: rtl/alu_uart_core_if.sv
// Request/result bundle between the chip top and alu_uart_core.
interface alu_uart_core_if #(
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned RES_W = 2 * DATA_W;

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        opcode;
    logic              tx_en;
    logic [RES_W-1:0]  result;
    logic              err;
    logic              busy;
    logic              done;
    logic              tx;

    modport master (
        output start, a, b, opcode, tx_en,
        input  result, err, busy, done, tx
    );

    modport slave (
        input  start, a, b, opcode, tx_en,
        output result, err, busy, done, tx
    );
endinterface

// File: rtl/alu_uart_core.sv
// ALU core: start-qualified operation, registered result, optional
// LSB-byte-first 8N1 serialisation of the result.
module alu_uart_core #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 16
) (
    input logic           clock,
    input logic           reset,
    alu_uart_core_if.slave bus
);
    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned NBYTES = RES_W / 8;
    localparam int unsigned CNT_W  = $clog2(CLK_DIV);
    localparam int unsigned BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [2:0]        op_q;
    logic              tx_en_q;
    logic [RES_W-1:0]  shreg;
    logic [CNT_W-1:0]  div_cnt;
    logic [3:0]        bit_idx;
    logic [BYTE_W-1:0] byte_idx;

    logic [RES_W-1:0]  alu_res;
    logic              alu_err;
    logic [RES_W-1:0]  a_x;
    logic [RES_W-1:0]  b_x;
    logic [DATA_W-1:0] shamt;

    // ALU datapath on the latched operands
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        a_x     = RES_W'(a_q);
        b_x     = RES_W'(b_q);
        shamt   = DATA_W'(b_q % DATA_W);
        case (op_q)
            3'b000: alu_res = a_x + b_x;
            3'b001: alu_res = a_x - b_x;
            3'b010: alu_res = a_x * b_x;
            3'b011: alu_res = a_x & b_x;
            3'b100: alu_res = a_x | b_x;
            3'b101: alu_res = a_x ^ b_x;
            3'b110: alu_res = a_x << shamt;
            default: begin
                if (b_q == '0) begin
                    alu_res = {a_q, {DATA_W{1'b1}}};
                    alu_err = 1'b1;
                end else begin
                    alu_res = {a_q % b_q, a_q / b_q};
                end
            end
        endcase
    end

    // Control FSM, UART shifter and registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_en_q    <= 1'b0;
            shreg      <= '0;
            div_cnt    <= '0;
            bit_idx    <= '0;
            byte_idx   <= '0;
            bus.result <= '0;
            bus.err    <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.tx     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    bus.tx   <= 1'b1;
                    if (bus.start) begin
                        a_q      <= bus.a;
                        b_q      <= bus.b;
                        op_q     <= bus.opcode;
                        tx_en_q  <= bus.tx_en;
                        bus.busy <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    bus.result <= alu_res;
                    bus.err    <= alu_err;
                    if (tx_en_q) begin
                        shreg    <= alu_res;
                        div_cnt  <= '0;
                        bit_idx  <= '0;
                        byte_idx <= '0;
                        bus.tx   <= 1'b0;
                        state    <= SEND;
                    end else begin
                        state <= DONE;
                    end
                end
                SEND: begin
                    if (div_cnt == CNT_W'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            if (byte_idx == BYTE_W'(NBYTES - 1)) begin
                                // Last stop bit finished: pulse done right away
                                bus.tx   <= 1'b1;
                                bus.busy <= 1'b0;
                                bus.done <= 1'b1;
                                state    <= DONE;
                            end else begin
                                byte_idx <= byte_idx + 1'b1;
                                bit_idx  <= '0;
                                shreg    <= shreg >> 8;
                                bus.tx   <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 4'd8) begin
                                bus.tx <= 1'b1;
                            end else begin
                                bus.tx <= shreg[bit_idx[2:0]];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE: local path enters with done low and pulses one cycle later
                    if (bus.done) begin
                        bus.done <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
